// File: rtl/riscv_pkg.sv
// Shared pipeline types: the MEM->WB payload record and the stage-register occupancy states.
package riscv_pkg;

    localparam int MW_XLEN = 32;
    localparam int MW_RW   = 5;
    localparam int MW_RSW  = 2;

    typedef struct packed {
        logic [MW_XLEN-1:0] aluresult;
        logic [MW_XLEN-1:0] readdata;
        logic [MW_RW-1:0]   rd;
        logic [MW_XLEN-1:0] pcplus4;
        logic               regwrite;
        logic [MW_RSW-1:0]  resultsrc;
    } mw_payload_t;

    typedef enum logic [1:0] {
        MW_EMPTY = 2'd0,
        MW_FULL  = 2'd1,
        MW_SKID  = 2'd2
    } mw_state_e;

    // Flattened payload width for arbitrary datapath parameters, same field order as mw_payload_t.
    function automatic int mw_payload_bits(input int xlen, input int rw, input int rsw);
        return 3 * xlen + rw + 1 + rsw;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic width-parametrised holding register used as the overflow slot of stage registers.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB stage register with valid/ready handshake; outputs always come from the main register.
// Define MEM_WB_SKID_EN for a two-entry skid version with registered readyM; default is single-entry.
module mem_wb_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RW   = 5,
    parameter int RSW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            validM,
    output logic            readyM,
    input  logic [XLEN-1:0] aluresultM,
    input  logic [XLEN-1:0] readdataM,
    input  logic [XLEN-1:0] pcplus4M,
    input  logic [RW-1:0]   rdM,
    input  logic            regwriteM,
    input  logic [RSW-1:0]  resultsrcM,
    output logic            validW,
    input  logic            readyW,
    output logic [XLEN-1:0] aluresultW,
    output logic [XLEN-1:0] readdataW,
    output logic [XLEN-1:0] pcplus4W,
    output logic [RW-1:0]   rdW,
    output logic            regwriteW,
    output logic [RSW-1:0]  resultsrcW
);

    localparam int PW = mw_payload_bits(XLEN, RW, RSW);

    mw_state_e      state_q, state_d;
    logic [PW-1:0]  main_q, main_d;
    logic [PW-1:0]  inBeat;
    logic           accept, deliver;
    logic           storedRegwrite;

    assign inBeat  = {aluresultM, readdataM, rdM, pcplus4M, regwriteM, resultsrcM};
    assign validW  = (state_q != MW_EMPTY);
    assign deliver = validW && readyW;
    assign accept  = validM && readyM;

`ifdef MEM_WB_SKID_EN
    logic          readyM_q, readyM_d;
    logic          skidLoad;
    logic [PW-1:0] skidData;

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (skidLoad),
        .d_i    (inBeat),
        .q_o    (skidData)
    );

    assign readyM = readyM_q;

    // Flush wins over any simultaneous accept/deliver; readyM is precomputed from the next state.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skidLoad = 1'b0;
        unique case (state_q)
            MW_EMPTY: begin
                if (accept) begin
                    state_d = MW_FULL;
                    main_d  = inBeat;
                end
            end
            MW_FULL: begin
                if (accept && deliver) begin
                    main_d = inBeat;
                end else if (accept) begin
                    state_d  = MW_SKID;
                    skidLoad = 1'b1;
                end else if (deliver) begin
                    state_d = MW_EMPTY;
                end
            end
            MW_SKID: begin
                if (deliver) begin
                    state_d = MW_FULL;
                    main_d  = skidData;
                end
            end
            default: state_d = MW_EMPTY;
        endcase
        if (flush) begin
            state_d  = MW_EMPTY;
            main_d   = main_q;
            skidLoad = 1'b0;
        end
        readyM_d = (state_d != MW_SKID);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readyM_q <= 1'b0;
        end else begin
            readyM_q <= readyM_d;
        end
    end
`else
    logic started_q;

    // Single entry: a new beat can only enter when the held one leaves on the same edge.
    assign readyM = started_q && (readyW || !validW);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        unique case (state_q)
            MW_EMPTY: begin
                if (accept) begin
                    state_d = MW_FULL;
                    main_d  = inBeat;
                end
            end
            MW_FULL: begin
                if (accept) begin
                    main_d = inBeat;
                end else if (deliver) begin
                    state_d = MW_EMPTY;
                end
            end
            default: state_d = MW_EMPTY;
        endcase
        if (flush) begin
            state_d = MW_EMPTY;
            main_d  = main_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MW_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    assign {aluresultW, readdataW, rdW, pcplus4W, storedRegwrite, resultsrcW} = main_q;
    assign regwriteW = validW && storedRegwrite;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: queue-based occupancy model plus literal scenario checks.
// Honours MEM_WB_SKID_EN to select two-entry or single-entry expectations.
module tb_mem_wb_pipe;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        validM = 1'b0;
    logic        readyW = 1'b0;
    logic [31:0] aluresultM = '0;
    logic [31:0] readdataM = '0;
    logic [31:0] pcplus4M = '0;
    logic [4:0]  rdM = '0;
    logic        regwriteM = 1'b0;
    logic [1:0]  resultsrcM = '0;
    logic        readyM, validW, regwriteW;
    logic [31:0] aluresultW, readdataW, pcplus4W;
    logic [4:0]  rdW;
    logic [1:0]  resultsrcW;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;
    bit started = 1'b0;
    mw_payload_t heldQ[$];

    always #5 clk = ~clk;

    mem_wb_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .validM     (validM),
        .readyM     (readyM),
        .aluresultM (aluresultM),
        .readdataM  (readdataM),
        .pcplus4M   (pcplus4M),
        .rdM        (rdM),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .validW     (validW),
        .readyW     (readyW),
        .aluresultW (aluresultW),
        .readdataW  (readdataW),
        .pcplus4W   (pcplus4W),
        .rdW        (rdW),
        .regwriteW  (regwriteW),
        .resultsrcW (resultsrcW)
    );

    task automatic expectEq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Capacity is two beats with the skid slot, one without; readyM follows from occupancy.
    function automatic bit modelReadyM();
`ifdef MEM_WB_SKID_EN
        return started && (heldQ.size() < 2);
`else
        return started && (heldQ.size() == 0 || readyW);
`endif
    endfunction

    function automatic mw_payload_t curBeat();
        mw_payload_t b;
        b.aluresult = aluresultM;
        b.readdata  = readdataM;
        b.rd        = rdM;
        b.pcplus4   = pcplus4M;
        b.regwrite  = regwriteM;
        b.resultsrc = resultsrcM;
        return b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            heldQ.delete();
            started = 1'b0;
        end else begin
            bit acc;
            bit del;
            acc = validM && modelReadyM();
            del = (heldQ.size() > 0) && readyW;
            if (flush) begin
                heldQ.delete();
            end else begin
                if (del) void'(heldQ.pop_front());
                if (acc) heldQ.push_back(curBeat());
            end
            started = 1'b1;
        end
    end

    task automatic checkOutput();
        bit expValid;
        expValid = heldQ.size() > 0;
        expectEq("validW", validW, expValid);
        expectEq("readyM", readyM, modelReadyM());
        expectEq("regwriteW", regwriteW, expValid ? heldQ[0].regwrite : 1'b0);
        if (expValid) begin
            expectEq("aluresultW", aluresultW, heldQ[0].aluresult);
            expectEq("readdataW", readdataW, heldQ[0].readdata);
            expectEq("pcplus4W", pcplus4W, heldQ[0].pcplus4);
            expectEq("rdW", rdW, heldQ[0].rd);
            expectEq("resultsrcW", resultsrcW, heldQ[0].resultsrc);
        end else if (!reset) begin
            expectEq("rstPayload", {aluresultW, readdataW, pcplus4W, rdW, resultsrcW}, '0);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic applyStimulus(input bit v, input bit rdy, input bit fl,
                                 input logic [31:0] alu, input logic [4:0] rd, input bit rw);
        @(posedge clk);
        #1;
        validM     = v;
        readyW     = rdy;
        flush      = fl;
        aluresultM = alu;
        rdM        = rd;
        regwriteM  = rw;
        readdataM  = $urandom;
        pcplus4M   = $urandom;
        resultsrcM = 2'($urandom_range(0, 3));
    endtask

    task automatic peek();
        @(negedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 1'b0;
        checkEn = 1'b1;
        #1;
        expectEq("rst_validW", validW, 1'b0);
        expectEq("rst_readyM", readyM, 1'b0);
        expectEq("rst_alu", aluresultW, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        peek();
        expectEq("preedge_readyM", readyM, 1'b0);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 0);
        expectEq("firstedge_readyM", readyM, 1'b1);

        // Single beat
        applyStimulus(1, 1, 0, 32'h0000_1234, 5'd5, 1);
        peek();
        expectEq("single_preValid", validW, 1'b0);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("single_validW", validW, 1'b1);
        expectEq("single_alu", aluresultW, 32'h0000_1234);
        expectEq("single_rd", rdW, 5'd5);
        expectEq("single_regwrite", regwriteW, 1'b1);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);

        // Back-to-back 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 1, 0, 32'(i), 5'(i), 1);
            peek();
            expectEq("b2b_readyM", readyM, 1'b1);
            if (i > 1) expectEq("b2b_alu", aluresultW, 32'(i - 1));
        end
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("b2b_last", aluresultW, 32'd8);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("b2b_drained", validW, 1'b0);

`ifdef MEM_WB_SKID_EN
        applyStimulus(1, 0, 0, 32'hA1, 5'd1, 1);
        peek();
        expectEq("skid_c1_readyM", readyM, 1'b1);
        applyStimulus(1, 0, 0, 32'hB2, 5'd2, 1);
        peek();
        expectEq("skid_c2_alu", aluresultW, 32'hA1);
        applyStimulus(1, 0, 0, 32'hC3, 5'd3, 1);
        peek();
        expectEq("skid_c3_readyM", readyM, 1'b0);
        expectEq("skid_c3_alu", aluresultW, 32'hA1);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("skid_out1", aluresultW, 32'hA1);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("skid_out2", aluresultW, 32'hB2);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("skid_empty", validW, 1'b0);

        applyStimulus(1, 0, 0, 32'hD4, 5'd4, 1);
        applyStimulus(1, 0, 0, 32'hE5, 5'd5, 1);
        applyStimulus(1, 0, 1, 32'hF6, 5'd6, 1);
        peek();
        expectEq("flush_inSkid", readyM, 1'b0);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("flush_validW", validW, 1'b0);
        expectEq("flush_regwrite", regwriteW, 1'b0);
        expectEq("flush_readyM", readyM, 1'b1);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("flush_dropped", validW, 1'b0);
`else
        applyStimulus(1, 0, 0, 32'h77, 5'd7, 1);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("stall_validW", validW, 1'b1);
        expectEq("stall_readyM", readyM, 1'b0);
        readyW = 1'b1;
        #1;
        expectEq("release_readyM", readyM, 1'b1);
        applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("release_drained", validW, 1'b0);

        applyStimulus(1, 0, 0, 32'h88, 5'd8, 1);
        applyStimulus(1, 1, 1, 32'h99, 5'd9, 1);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("flush_validW", validW, 1'b0);
        expectEq("flush_regwrite", regwriteW, 1'b0);
        expectEq("flush_readyM", readyM, 1'b1);
`endif

        // Asynchronous reset while a beat is held
        applyStimulus(1, 0, 0, 32'hCAFE, 5'd11, 1);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("arst_preValid", validW, 1'b1);
        reset = 1'b0;
        #1;
        expectEq("arst_validW", validW, 1'b0);
        expectEq("arst_readyM", readyM, 1'b0);
        expectEq("arst_alu", aluresultW, 32'h0);
        expectEq("arst_rd", rdW, 5'd0);
        expectEq("arst_regwrite", regwriteW, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Randomised traffic checked every cycle against the occupancy model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
                          $urandom, 5'($urandom), 1'($urandom));
        end
        for (int n = 0; n < 4; n++) applyStimulus(0, 1, 0, 32'h0, 5'd0, 0);
        peek();
        expectEq("final_drained", validW, 1'b0);
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
